alu_issue: RTL and testbench
============================

// Module: alu_issue
// PURPOSE
//  Issue stage in front of the combinational ALU. Decodes a MIPS instruction plus its register-file
//  operands into the ALU's A/B/ALUfn inputs and a destination register, then registers them.
//  A valid/ready handshake on both sides and a one-entry skid buffer let the stage absorb
//  back-pressure from the ALU/writeback side without dropping or duplicating work.
// PARAMETERS
//  N        32  datapath width of A/B and the operand inputs; must be >= 17
// PORTS
//  clock        in   1   system clock, rising edge
//  reset_n      in   1   asynchronous, active-low reset
//  in_valid     in   1   upstream presents instr/rs_data/rt_data
//  in_ready     out  1   stage can accept this cycle
//  instr        in   32  MIPS instruction word
//  rs_data      in   N   value of register rs
//  rt_data      in   N   value of register rt
//  out_valid    out  1   A/B/ALUfn/dest valid
//  out_ready    in   1   downstream consumes this cycle
//  A, B         out  N   ALU operands
//  ALUfn        out  5   {subtract,bool1,bool0,shft,math}
//  dest         out  5   destination register number
//  we           out  1   write-enable for dest
//  illegal      out  1   instruction not supported by this stage
// BEHAVIOUR
//  ALUfn codes: add 00001, sub 10001, and 00000, or 00100, xor 01000, nor 01100,
//   slt 10011, sltu 10111, sll 00010, srl 01010, sra 01110.
//  R-type (op=0), dest=rd, B=rt_data: funct 20/21 add, 22/23 sub, 24 and, 25 or, 26 xor, 27 nor,
//   2A slt, 2B sltu, A=rs_data. funct 00/02/03 sll/srl/sra: A=zero-ext shamt.
//   funct 04/06/07 sllv/srlv/srav: A=rs_data (ALU uses low log2(N) bits).
//  I-type, dest=rt, A=rs_data: op 08/09 add, 0A slt, 0B sltu with B=sign-ext imm16;
//   0C and, 0D or, 0E xor with B=zero-ext imm16. op 0F lui: ALUfn=sll, A=16, B=zero-ext imm16.
//  Anything else: illegal=1, we=0, ALUfn=00001, A=B=0, dest=0. Legal ops: we=1, illegal=0.
//  Latency: 1 cycle; an instruction accepted at edge k is on the outputs after edge k.
//  Transfer occurs when valid&ready on that side at a rising edge.
//  in_ready = ~skid_full (registered; never combinationally from out_ready).
//  States: EMPTY (out_valid=0), ONE (output reg full), TWO (output + skid full, in_ready=0).
//   EMPTY: accept -> ONE.  ONE: accept&consume -> ONE (new data); accept&~consume -> TWO
//   (new data to skid); consume only -> EMPTY.  TWO: consume -> ONE (skid moves to output).
//  Output registers change only on a load; they hold while out_valid&~out_ready. Order is FIFO.
//  Reset (asynchronous, any state incl. TWO): state EMPTY, out_valid=0, in_ready=1, A=B=0,
//   ALUfn=0, dest=0, we=0, illegal=0, skid cleared. In-flight entries are discarded.
//  Decode is purely from instr; rs_data/rt_data sampled on the same accepting edge.
// TESTING
//  add $3,$1,$2 (0x00221820), rs=5, rt=7 -> A=5, B=7, ALUfn=00001, dest=3, we=1, 1 cycle later.
//  addi $2,$1,-1 (0x2022FFFF) -> B=0xFFFFFFFF, ALUfn=00001, dest=2; sra $4,$2,3 (0x000220C3)
//   -> A=3, B=rt_data, ALUfn=01110, dest=4.
//  lui $5,0x1234 (0x3C051234) -> A=16, B=0x00001234, ALUfn=00010, dest=5, we=1.
//  out_ready=0, three back-to-back in_valid: two accepted, in_ready=0 after the second, third
//   held; out_ready=1 -> all three emitted in order, no loss or duplicate.
//  Opcode 0x3F (0xFC000000) -> illegal=1, we=0, handshake completes normally.
//  reset_n low while in TWO -> out_valid=0, in_ready=1 immediately, without a clock edge.

Source files
------------

// File: rtl/alu_issue.sv
// alu_issue: issue stage in front of the combinational ALU.
//   Decodes a MIPS instruction plus its register operands into the ALU A/B/ALUfn
//   inputs and a destination register, then registers them. A one-entry skid
//   buffer absorbs back-pressure so nothing is dropped or duplicated.
// Ports:
//   clock, reset_n         rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready      upstream handshake (instr, rs_data, rt_data)
//   out_valid/out_ready    downstream handshake (A, B, ALUfn, dest, we, illegal)
//   ALUfn = {subtract, bool1, bool0, shft, math}
module alu_issue #(
  parameter int N = 32
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [31:0]  instr,
  input  logic [N-1:0] rs_data,
  input  logic [N-1:0] rt_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] A,
  output logic [N-1:0] B,
  output logic [4:0]   ALUfn,
  output logic [4:0]   dest,
  output logic         we,
  output logic         illegal
);

  localparam logic [4:0] FN_ADD  = 5'b00001;
  localparam logic [4:0] FN_SUB  = 5'b10001;
  localparam logic [4:0] FN_AND  = 5'b00000;
  localparam logic [4:0] FN_OR   = 5'b00100;
  localparam logic [4:0] FN_XOR  = 5'b01000;
  localparam logic [4:0] FN_NOR  = 5'b01100;
  localparam logic [4:0] FN_SLT  = 5'b10011;
  localparam logic [4:0] FN_SLTU = 5'b10111;
  localparam logic [4:0] FN_SLL  = 5'b00010;
  localparam logic [4:0] FN_SRL  = 5'b01010;
  localparam logic [4:0] FN_SRA  = 5'b01110;

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  function automatic logic [N-1:0] sext16(input logic [15:0] v);
    return {{(N-16){v[15]}}, v};
  endfunction

  function automatic logic [N-1:0] zext16(input logic [15:0] v);
    return {{(N-16){1'b0}}, v};
  endfunction

  function automatic logic [N-1:0] zext5(input logic [4:0] v);
    return {{(N-5){1'b0}}, v};
  endfunction

  logic [5:0]  op, funct;
  logic [4:0]  rt, rd, shamt;
  logic [15:0] imm;
  logic        unused_rs;

  assign op        = instr[31:26];
  assign rt        = instr[20:16];
  assign rd        = instr[15:11];
  assign shamt     = instr[10:6];
  assign funct     = instr[5:0];
  assign imm       = instr[15:0];
  // The rs register number is resolved upstream; only its value arrives here.
  assign unused_rs = ^instr[25:21];

  logic [N-1:0] d_a, d_b;
  logic [4:0]   d_fn, d_dest;
  logic         d_ok;

  always_comb begin
    d_a    = '0;
    d_b    = '0;
    d_fn   = FN_ADD;
    d_dest = '0;
    d_ok   = 1'b1;
    if (op == 6'h00) begin
      d_dest = rd;
      d_b    = rt_data;
      d_a    = rs_data;
      unique case (funct)
        6'h20, 6'h21: d_fn = FN_ADD;
        6'h22, 6'h23: d_fn = FN_SUB;
        6'h24:        d_fn = FN_AND;
        6'h25:        d_fn = FN_OR;
        6'h26:        d_fn = FN_XOR;
        6'h27:        d_fn = FN_NOR;
        6'h2A:        d_fn = FN_SLT;
        6'h2B:        d_fn = FN_SLTU;
        6'h00: begin d_fn = FN_SLL; d_a = zext5(shamt); end
        6'h02: begin d_fn = FN_SRL; d_a = zext5(shamt); end
        6'h03: begin d_fn = FN_SRA; d_a = zext5(shamt); end
        6'h04:        d_fn = FN_SLL;
        6'h06:        d_fn = FN_SRL;
        6'h07:        d_fn = FN_SRA;
        default:      d_ok = 1'b0;
      endcase
    end else begin
      d_dest = rt;
      d_a    = rs_data;
      unique case (op)
        6'h08, 6'h09: begin d_fn = FN_ADD;  d_b = sext16(imm); end
        6'h0A:        begin d_fn = FN_SLT;  d_b = sext16(imm); end
        6'h0B:        begin d_fn = FN_SLTU; d_b = sext16(imm); end
        6'h0C:        begin d_fn = FN_AND;  d_b = zext16(imm); end
        6'h0D:        begin d_fn = FN_OR;   d_b = zext16(imm); end
        6'h0E:        begin d_fn = FN_XOR;  d_b = zext16(imm); end
        // lui is an sll of the zero-extended immediate by 16.
        6'h0F:        begin d_fn = FN_SLL;  d_b = zext16(imm); d_a = N'(16); end
        default:      d_ok = 1'b0;
      endcase
    end
    if (!d_ok) begin
      d_a    = '0;
      d_b    = '0;
      d_fn   = FN_ADD;
      d_dest = '0;
    end
  end

  state_t state, state_nx;
  logic   accept, consume, load_out, load_skid, from_skid;

  // in_ready depends only on the state register, never on out_ready.
  assign in_ready  = (state != TWO);
  assign out_valid = (state != EMPTY);
  assign accept    = in_valid & in_ready;
  assign consume   = out_valid & out_ready;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= EMPTY;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    load_out  = 1'b0;
    load_skid = 1'b0;
    from_skid = 1'b0;
    case (state)
      EMPTY: if (accept) begin state_nx = ONE; load_out = 1'b1; end
      ONE: begin
        if (accept && consume)   load_out = 1'b1;
        else if (accept) begin   state_nx = TWO; load_skid = 1'b1; end
        else if (consume)        state_nx = EMPTY;
      end
      TWO: if (consume) begin state_nx = ONE; load_out = 1'b1; from_skid = 1'b1; end
      default: state_nx = EMPTY;
    endcase
  end

  logic [N-1:0] skid_a, skid_b;
  logic [4:0]   skid_fn, skid_dest;
  logic         skid_ok;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      skid_a    <= '0;
      skid_b    <= '0;
      skid_fn   <= '0;
      skid_dest <= '0;
      skid_ok   <= 1'b0;
    end else if (load_skid) begin
      skid_a    <= d_a;
      skid_b    <= d_b;
      skid_fn   <= d_fn;
      skid_dest <= d_dest;
      skid_ok   <= d_ok;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      A       <= '0;
      B       <= '0;
      ALUfn   <= '0;
      dest    <= '0;
      we      <= 1'b0;
      illegal <= 1'b0;
    end else if (load_out) begin
      A       <= from_skid ? skid_a    : d_a;
      B       <= from_skid ? skid_b    : d_b;
      ALUfn   <= from_skid ? skid_fn   : d_fn;
      dest    <= from_skid ? skid_dest : d_dest;
      we      <= from_skid ? skid_ok   : d_ok;
      illegal <= from_skid ? ~skid_ok  : ~d_ok;
    end
  end

endmodule

// File: tb/tb_alu_issue.sv
// tb_alu_issue: directed bench for alu_issue (N=32).
module tb_alu_issue;

  logic        clock = 1'b0;
  logic        reset_n, in_valid, in_ready, out_valid, out_ready, we, illegal;
  logic [31:0] instr, rs_data, rt_data, A, B;
  logic [4:0]  ALUfn, dest;

  int errors = 0;
  int checks = 0;

  alu_issue #(.N(32)) dut (
    .clock(clock), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .rs_data(rs_data), .rt_data(rt_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .A(A), .B(B), .ALUfn(ALUfn), .dest(dest), .we(we), .illegal(illegal)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [31:0] ea, input logic [31:0] eb,
                         input logic [4:0] efn, input logic [4:0] ed,
                         input logic ewe, input logic eill);
    chk({tag, ".valid"}, 64'(out_valid), 64'd1);
    chk({tag, ".A"}, 64'(A), 64'(ea));
    chk({tag, ".B"}, 64'(B), 64'(eb));
    chk({tag, ".fn"}, 64'(ALUfn), 64'(efn));
    chk({tag, ".dest"}, 64'(dest), 64'(ed));
    chk({tag, ".we"}, 64'(we), 64'(ewe));
    chk({tag, ".ill"}, 64'(illegal), 64'(eill));
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic [31:0] i, input logic [31:0] rs, input logic [31:0] rt);
    instr = i; rs_data = rs; rt_data = rt; in_valid = 1'b1;
  endtask

  // One accepted instruction with out_ready high; outputs checked one cycle later.
  task automatic send(input logic [31:0] i, input logic [31:0] rs, input logic [31:0] rt);
    drive(i, rs, rt);
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    instr = '0; rs_data = '0; rt_data = '0;
    #2;
    chk("rst.valid", 64'(out_valid), 64'd0);
    chk("rst.ready", 64'(in_ready), 64'd1);
    chk("rst.A", 64'(A), 64'd0);
    chk("rst.B", 64'(B), 64'd0);
    chk("rst.fn", 64'(ALUfn), 64'd0);
    chk("rst.dest", 64'(dest), 64'd0);
    chk("rst.we", 64'(we), 64'd0);
    chk("rst.ill", 64'(illegal), 64'd0);
    #11 reset_n = 1'b1;
    tick();

    send(32'h00221820, 32'd5, 32'd7);                 // add $3,$1,$2
    chk_out("add", 32'd5, 32'd7, 5'b00001, 5'd3, 1'b1, 1'b0);
    send(32'h2022FFFF, 32'd10, 32'd0);                // addi $2,$1,-1
    chk_out("addi", 32'd10, 32'hFFFFFFFF, 5'b00001, 5'd2, 1'b1, 1'b0);
    send(32'h000220C3, 32'd9, 32'h80000000);          // sra $4,$2,3
    chk_out("sra", 32'd3, 32'h80000000, 5'b01110, 5'd4, 1'b1, 1'b0);
    send(32'h3C051234, 32'd99, 32'd0);                // lui $5,0x1234
    chk_out("lui", 32'd16, 32'h00001234, 5'b00010, 5'd5, 1'b1, 1'b0);
    send(32'h0022182A, 32'd1, 32'd2);                 // slt $3,$1,$2
    chk_out("slt", 32'd1, 32'd2, 5'b10011, 5'd3, 1'b1, 1'b0);
    send(32'h3425ABCD, 32'd4, 32'd0);                 // ori $5,$1,0xABCD
    chk_out("ori", 32'd4, 32'h0000ABCD, 5'b00100, 5'd5, 1'b1, 1'b0);
    send(32'h00221806, 32'h21, 32'h1000);             // srlv $3,$2,$1
    chk_out("srlv", 32'h21, 32'h1000, 5'b01010, 5'd3, 1'b1, 1'b0);
    send(32'h0022182B, 32'd6, 32'd8);                 // sltu $3,$1,$2
    chk_out("sltu", 32'd6, 32'd8, 5'b10111, 5'd3, 1'b1, 1'b0);
    send(32'hFC000000, 32'd5, 32'd7);                 // opcode 0x3F
    chk_out("ill", 32'd0, 32'd0, 5'b00001, 5'd0, 1'b0, 1'b1);
    tick();
    chk("ill.drain", 64'(out_valid), 64'd0);

    // Back-pressure: three back-to-back offers with the output stalled.
    out_ready = 1'b0;
    drive(32'h00221820, 32'h11, 32'h1);
    tick();
    chk("bp1.ready", 64'(in_ready), 64'd1);
    drive(32'h00221822, 32'h22, 32'h2);               // sub
    tick();
    chk("bp2.ready", 64'(in_ready), 64'd0);
    chk("bp2.A", 64'(A), 64'h11);
    drive(32'h00221824, 32'h33, 32'h3);               // and, held off
    tick();
    chk("bp3.ready", 64'(in_ready), 64'd0);
    chk_out("bp3.hold", 32'h11, 32'h1, 5'b00001, 5'd3, 1'b1, 1'b0);
    out_ready = 1'b1;
    tick();
    chk_out("bp.o2", 32'h22, 32'h2, 5'b10001, 5'd3, 1'b1, 1'b0);
    chk("bp.o2.ready", 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    chk_out("bp.o3", 32'h33, 32'h3, 5'b00000, 5'd3, 1'b1, 1'b0);
    tick();
    chk("bp.drain", 64'(out_valid), 64'd0);

    // Asynchronous reset while both registers are full.
    out_ready = 1'b0;
    drive(32'h00221820, 32'h44, 32'h4);
    tick();
    drive(32'h00221820, 32'h55, 32'h5);
    tick();
    in_valid = 1'b0;
    chk("two.ready", 64'(in_ready), 64'd0);
    #2 reset_n = 1'b0;
    #1;
    chk("arst.valid", 64'(out_valid), 64'd0);
    chk("arst.ready", 64'(in_ready), 64'd1);
    chk("arst.A", 64'(A), 64'd0);
    chk("arst.we", 64'(we), 64'd0);
    #4 reset_n = 1'b1;
    out_ready = 1'b1;
    tick();
    chk("arst.empty", 64'(out_valid), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
